// File: rtl/down_counter_timer_if.sv
// Control and status bundle for the loadable down-counter timer.
interface down_counter_timer_if #(
    parameter int NUM_CNT_BITS = 4
) ();
    logic                    clear;
    logic                    load;
    logic [NUM_CNT_BITS-1:0] load_val;
    logic                    auto_reload;
    logic                    count_enable;
    logic [NUM_CNT_BITS-1:0] count_out;
    logic                    zero_flag;
    logic                    busy;
    logic                    expired;

    modport master (
        output clear, load, load_val,
        output auto_reload, count_enable,
        input  count_out, zero_flag,
        input  busy, expired
    );

    modport slave (
        input  clear, load, load_val,
        input  auto_reload, count_enable,
        output count_out, zero_flag,
        output busy, expired
    );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter with one-shot or auto-reload terminal count.
// Terminal event is the enabled cycle that sees count==1.
module down_counter_timer #(
    parameter int NUM_CNT_BITS = 4
) (
    input logic                  clk,
    input logic                  nRST,
    down_counter_timer_if.slave  bus
);
    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [NUM_CNT_BITS-1:0] ONE = 1;

    state_t                  state_q, state_n;
    logic [NUM_CNT_BITS-1:0] cnt_q, cnt_n;
    logic [NUM_CNT_BITS-1:0] rld_q, rld_n;
    logic                    zero_q, zero_n;
    logic                    exp_q, exp_n;

    logic do_clr;
    logic do_ld;
    logic do_dec;

    assign do_clr = bus.clear;
    assign do_ld  = bus.load & ~bus.clear;
    assign do_dec = bus.count_enable & (state_q == RUN)
                  & ~bus.load & ~bus.clear;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        rld_n   = rld_q;
        zero_n  = 1'b0;
        exp_n   = exp_q;
        unique case (1'b1)
            do_clr: begin
                state_n = IDLE;
                cnt_n   = '0;
                exp_n   = 1'b0;
            end
            do_ld: begin
                cnt_n   = bus.load_val;
                rld_n   = bus.load_val;
                exp_n   = 1'b0;
                state_n = (bus.load_val != '0) ? RUN : IDLE;
            end
            do_dec: begin
                if (cnt_q > ONE) begin
                    cnt_n = cnt_q - ONE;
                end else begin
                    // Never step below zero; reload or park at zero.
                    zero_n = 1'b1;
                    exp_n  = 1'b1;
                    if (bus.auto_reload) begin
                        cnt_n = rld_q;
                    end else begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rld_q   <= '0;
            zero_q  <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            rld_q   <= rld_n;
            zero_q  <= zero_n;
            exp_q   <= exp_n;
        end
    end

    assign bus.count_out = cnt_q;
    assign bus.zero_flag = zero_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.expired   = exp_q;
endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counter: the counterpart to the up-counting rollover counter.
- Software or FSM logic loads a start value. The block decrements on each enabled cycle and signals terminal count (reaching zero) with a registered one-cycle flag.
- Two modes: one-shot (stop at 0) and auto-reload (periodic tick generator).
- Used in testbench and control paths for timeouts, wait-states and periodic strobes.

Parameters:
- NUM_CNT_BITS, 4, width of counter, load value and reload register.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous clear; highest priority after reset.
- load  input  1  synchronous load of load_val; priority over count_enable.
- load_val  input  NUM_CNT_BITS  start/reload value, captured when load=1.
- auto_reload  input  1  mode select, sampled at the terminal event: 1 = reload, 0 = one-shot.
- count_enable  input  1  decrement qualifier; effective only while busy=1.
- count_out  output  NUM_CNT_BITS  current count, registered.
- zero_flag  output  1  registered terminal-count pulse.
- busy  output  1  counter armed and counting.
- expired  output  1  sticky: at least one terminal event since the last load or clear.

Behaviour:
- Reset (nRST=0, async):
  - count_out=0, zero_flag=0, busy=0, expired=0.
  - Internal reload_reg=0.
  - Reset mid-count abandons the count immediately; no flag is generated.
- Priority per cycle: clear > load > count_enable > hold.
- clear=1:
  - Next cycle: count_out=0, zero_flag=0, busy=0, expired=0.
  - reload_reg unchanged.
- load=1 (clear=0):
  - Next cycle: count_out=load_val, reload_reg=load_val, zero_flag=0, expired=0.
  - busy=1 if load_val!=0, else busy=0.
  - load_val=0 generates no terminal event.
  - Load overrides a simultaneous terminal event; no flag is produced.
- count_enable=1, busy=1, count_out>1: count_out decrements by 1; zero_flag=0.
- count_enable=1, busy=1, count_out==1 (terminal event). Next cycle:
  - zero_flag=1 and expired=1.
  - If auto_reload=0: count_out=0, busy=0.
  - If auto_reload=1: count_out=reload_reg, busy stays 1.
  - Period in auto mode is reload_reg enabled cycles.
- zero_flag is a one-cycle pulse. It deasserts the cycle after a terminal event unless another terminal event occurs that cycle.
  - With reload_reg=1 in auto mode, zero_flag stays high on every enabled cycle.
  - zero_flag is always 0 on non-enabled cycles.
- count_enable=0: all state holds; zero_flag returns to 0.
- count_enable while busy=0: no effect; count_out holds at 0 or the last value.
- Wrap-around: arithmetic is unsigned NUM_CNT_BITS wide. The counter never decrements below 0; underflow to all-ones is prohibited.
- Max load value is 2^NUM_CNT_BITS-1 (15 at default).
- expired stays 1 until the next load or clear; auto-reload events keep it at 1.
- Latency:
  - load to first decrement: the first enabled cycle after the load edge.
  - The terminal flag is visible one clock after the enabled cycle that sees count_out==1.
- Suggested structure: 2-state FSM IDLE/RUN (busy = state==RUN), next-state logic in always_comb, registers in a single always_ff with async reset.

Test Plan:
- Reset then idle: assert nRST=0 mid-sequence with count_out=5 -> count_out=0, busy=0, zero_flag=0, expired=0 immediately; count_enable then has no effect.
- One-shot: load_val=3, auto_reload=0, count_enable held 1 -> count_out 3,2,1,0. zero_flag=1 only on the cycle count_out becomes 0. busy falls at the same edge. expired=1 thereafter, and count_out stays 0.
- Auto-reload: load_val=4, auto_reload=1, count_enable=1 for 12 cycles -> count_out sequence 4,3,2,1,4,3,2,1,4,3,2,1,4. zero_flag pulses on each 1->4 transition (3 pulses). busy stays 1.
- Gated enable and reload of 1: load_val=1, auto_reload=1, count_enable pattern 1,1,0,1 -> zero_flag 1,1,0,1 and count_out constant 1. Then load_val=5 with count_enable toggling 1,0 -> decrements only on enabled cycles: 5,4,4,3,3,...
- Priority collisions:
  - load_val=7 asserted on the same cycle as a terminal event -> count_out=7, zero_flag=0, expired=0.
  - clear and load together -> count_out=0, busy=0.
  - load_val=0 -> busy=0, zero_flag never asserts.
- Width corner: NUM_CNT_BITS=4, load_val=15, one-shot -> exactly 15 enabled cycles to reach 0. No underflow after further enables; count_out stays 0 and zero_flag stays 0.
